// File: rtl/regfile_write_buffer_if.sv
// Handshake and drain bundle for the register-file write buffer.
// Producer side is master, buffer side is slave.
interface regfile_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          drain_hold;

  logic          Reg_Write;
  logic [AW-1:0] Write_Reg;
  logic [DW-1:0] Write_Data;

  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  logic [AW-1:0] lk_reg1;
  logic [AW-1:0] lk_reg2;
  logic          lk_hit1;
  logic          lk_hit2;
  logic [DW-1:0] lk_data1;
  logic [DW-1:0] lk_data2;

  modport master (
    output in_valid, in_reg, in_data, drain_hold,
    output lk_reg1, lk_reg2,
    input  in_ready, Reg_Write, Write_Reg, Write_Data,
    input  count, empty, full,
    input  lk_hit1, lk_hit2, lk_data1, lk_data2
  );

  modport slave (
    input  in_valid, in_reg, in_data, drain_hold,
    input  lk_reg1, lk_reg2,
    output in_ready, Reg_Write, Write_Reg, Write_Data,
    output count, empty, full,
    output lk_hit1, lk_hit2, lk_data1, lk_data2
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order write FIFO feeding the single register-file write port.
// Define WRBUF_BYPASS_EN to enable forwarding lookups over queued entries.
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                 clk,
  input logic                 rst,
  regfile_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] reg_q  [DEPTH];
  logic [AW-1:0] reg_d  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];

  logic          empty_w;
  logic          full_w;
  logic          push_hs;
  logic          push_en;
  logic          pop_en;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // Register 0 writes complete the handshake but are never stored.
  assign push_hs = bus.in_valid && !full_w;
  assign push_en = push_hs && (bus.in_reg != '0);
  assign pop_en  = !empty_w && !bus.drain_hold;

  assign bus.in_ready = !full_w;
  assign bus.count    = count_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;

  // Drain port: head entry presented whenever something is queued.
  always_comb begin
    bus.Reg_Write  = pop_en;
    bus.Write_Reg  = '0;
    bus.Write_Data = '0;
    if (!empty_w) begin
      bus.Write_Reg  = reg_q[rd_ptr_q];
      bus.Write_Data = data_q[rd_ptr_q];
    end
  end

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    reg_d    = reg_q;
    data_d   = data_q;
    if (push_en) begin
      reg_d[wr_ptr_q]  = bus.in_reg;
      data_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards every pending entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
    end
  end

`ifdef WRBUF_BYPASS_EN
  logic          hit1, hit2;
  logic [DW-1:0] dat1, dat2;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    dat1 = '0;
    dat2 = '0;
    for (int k = 0; k < DEPTH; k++) begin : scan
      logic [PW-1:0] idx;
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q) begin
        if (bus.lk_reg1 != '0 && reg_q[idx] == bus.lk_reg1) begin
          hit1 = 1'b1;
          dat1 = data_q[idx];
        end
        if (bus.lk_reg2 != '0 && reg_q[idx] == bus.lk_reg2) begin
          hit2 = 1'b1;
          dat2 = data_q[idx];
        end
      end
    end
  end

  assign bus.lk_hit1  = hit1;
  assign bus.lk_hit2  = hit2;
  assign bus.lk_data1 = dat1;
  assign bus.lk_data2 = dat2;
`else
  logic unused_lk;
  assign unused_lk    = ^{bus.lk_reg1, bus.lk_reg2};
  assign bus.lk_hit1  = 1'b0;
  assign bus.lk_hit2  = 1'b0;
  assign bus.lk_data1 = '0;
  assign bus.lk_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Randomized bench for regfile_write_buffer against a queue model.
// Lookup expectations follow WRBUF_BYPASS_EN.
module tb_regfile_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
`ifdef WRBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ent_t          q[$];
  logic [DW-1:0] exp_rf [32];
  logic [DW-1:0] dut_rf [32];

  regfile_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  regfile_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Register file behaviour: capture on negedge.
  always @(negedge clk) begin
    if (!rst && bus.Reg_Write) dut_rf[bus.Write_Reg] = bus.Write_Data;
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW:0] model_lk(logic [AW-1:0] a);
    if (!BYP || a == '0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].r == a) return {1'b1, q[i].d};
    return '0;
  endfunction

  task automatic check_outputs(logic h, logic [AW-1:0] l1, logic [AW-1:0] l2);
    int n;
    ent_t hd;
    logic [DW:0] e1, e2;
    n  = q.size();
    hd = '0;
    if (n != 0) hd = q[0];
    e1 = model_lk(l1);
    e2 = model_lk(l2);
    check("in_ready", bus.in_ready, n < DEPTH);
    check("count", bus.count, n);
    check("empty", bus.empty, n == 0);
    check("full", bus.full, n == DEPTH);
    check("reg_write", bus.Reg_Write, (n != 0) && !h);
    check("write_reg", bus.Write_Reg, hd.r);
    check("write_data", bus.Write_Data, hd.d);
    check("lk_hit1", bus.lk_hit1, e1[DW]);
    check("lk_data1", bus.lk_data1, e1[DW-1:0]);
    check("lk_hit2", bus.lk_hit2, e2[DW]);
    check("lk_data2", bus.lk_data2, e2[DW-1:0]);
  endtask

  // One cycle: drive, check, clock, update model. Starts/ends at posedge+1.
  task automatic step(logic v, logic [AW-1:0] r, logic [DW-1:0] d,
                      logic h, logic [AW-1:0] l1, logic [AW-1:0] l2);
    bit acc, pop;
    ent_t hd;
    bus.in_valid   = v;
    bus.in_reg     = r;
    bus.in_data    = d;
    bus.drain_hold = h;
    bus.lk_reg1    = l1;
    bus.lk_reg2    = l2;
    #1;
    check_outputs(h, l1, l2);
    acc = v && (q.size() < DEPTH);
    pop = (q.size() != 0) && !h;
    @(posedge clk);
    #1;
    if (pop) begin
      hd = q.pop_front();
      exp_rf[hd.r] = hd.d;
    end
    if (acc && r != '0) q.push_back({r, d});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = '0;
      dut_rf[i] = '0;
    end
    bus.in_valid = 1'b0; bus.in_reg = '0; bus.in_data = '0;
    bus.drain_hold = 1'b0; bus.lk_reg1 = '0; bus.lk_reg2 = '0;
    #2;
    check_outputs(1'b0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write
    step(1'b1, 5'd5, 32'hAA, 1'b0, 5'd5, '0);
    check("single_rw", bus.Reg_Write, 1'b1);
    check("single_reg", bus.Write_Reg, 5);
    check("single_data", bus.Write_Data, 32'hAA);
    idle(1);
    check("single_empty", bus.empty, 1'b1);

    // Fill under hold, refuse 5th, then drain
    for (int i = 1; i <= 4; i++)
      step(1'b1, AW'(i), DW'(i * 32'h11), 1'b1, AW'(i), '0);
    step(1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd4);
    check("fill_count", bus.count, 4);
    check("fill_ready", bus.in_ready, 1'b0);
    idle(5);

    // Register 0 is dropped
    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, '0, '0);
    check("r0_count", bus.count, 0);
    check("r0_ready", bus.in_ready, 1'b1);
    idle(1);

    // Simultaneous push/pop keeps count at 2
    step(1'b1, 5'd10, 32'hA0, 1'b1, '0, '0);
    step(1'b1, 5'd11, 32'hB0, 1'b1, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, AW'(12 + i), DW'(32'hC0 + i), 1'b0, AW'(11 + i), '0);
      check("sim_count", bus.count, 2);
    end
    idle(3);

    // Forwarding of youngest value
    step(1'b1, 5'd7, 32'h1, 1'b1, '0, '0);
    step(1'b1, 5'd7, 32'h2, 1'b1, '0, '0);
    step(1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    bus.lk_reg1 = 5'd7; #1;
    check("byp_hit1", bus.lk_hit1, BYP);
    check("byp_data1", bus.lk_data1, BYP ? 32'h2 : 32'h0);
    check("byp_hit2", bus.lk_hit2, 1'b0);
    idle(3);

    // Asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(20 + i), DW'(32'h300 + i), 1'b1, '0, '0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_rw", bus.Reg_Write, 1'b0);
    check("rst_count", bus.count, 0);
    check("rst_full", bus.full, 1'b0);
    check("rst_ready", bus.in_ready, 1'b1);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // Randomized traffic with register collisions
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)),
           $urandom, 1'($urandom_range(0, 3) == 0),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    idle(DEPTH + 2);

    for (int i = 0; i < 32; i++)
      check($sformatf("rf%0d", i), dut_rf[i], exp_rf[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Write-side front end for the pipeline register file.
- Queues register writes from the writeback/long-latency producers in an in-order FIFO and drains at most one per cycle onto the register file's single write port (Reg_Write / Write_Reg / Write_Data).
- Optionally provides forwarding lookups so read-stage logic sees queued-but-unwritten values.
- Sits between the WB stage and the register file; decouples producer bursts from the single write port.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  producer presents a write.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_reg  input  AW  destination register of offered write.
- in_data  input  DW  data of offered write.
- drain_hold  input  1  when 1, suppress drain this cycle.
- Reg_Write  output  1  write enable to register file.
- Write_Reg  output  AW  write address to register file.
- Write_Data  output  DW  write data to register file.
- count  output  $clog2(DEPTH)+1  current occupancy.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- lk_reg1, lk_reg2  input  AW  forwarding lookup addresses.
- lk_hit1, lk_hit2  output  1  lookup matched a queued entry.
- lk_data1, lk_data2  output  DW  data of matching entry.

Behaviour:
- Reset (async, rst=1): rd/wr pointers = 0, count = 0; all pending entries discarded. Reg_Write=0, Write_Reg=0, Write_Data=0, empty=1, full=0, in_ready=1, lk_hit*=0, lk_data*=0. Reset mid-drain drops the head immediately; no partial write is issued after rst deasserts.
- Push: at posedge, when in_valid && in_ready && in_reg != 0, the entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - A handshake with in_reg == 0 completes (in_valid && in_ready) but nothing is stored; register 0 stays constant zero.
- Drain outputs (combinational from registered state):
  - Reg_Write = !empty && !drain_hold.
  - Write_Reg / Write_Data = head entry when !empty, else 0.
  - The register file captures on negedge of the same cycle.
- Pop: at posedge, when Reg_Write == 1, rd_ptr increments (wrap modulo DEPTH).
- Latency: on an empty buffer, an entry pushed at posedge k drives Reg_Write during cycle k..k+1, is written at the intervening negedge, and is popped at posedge k+1. Buffer-to-regfile latency is 1 cycle.
- Simultaneous push and pop: count unchanged; both pointers advance.
- in_ready does not account for a same-cycle pop. When full, a push is refused even if a pop occurs; in_ready rises the cycle after the pop.
- count update: +1 on push-only, -1 on pop-only, unchanged otherwise. Never exceeds DEPTH; never underflows.
- drain_hold = 1: no pop, Reg_Write = 0; pushes still accepted while !full.
- Ordering: strictly FIFO. Multiple entries to the same register drain oldest-first; the register file ends with the youngest value.

Optional Feature:
- Macro: WRBUF_BYPASS_EN.
- Defined: lk_hit1 = 1 when lk_reg1 != 0 and any valid entry (including the head) has Write_Reg == lk_reg1. lk_data1 = data of the youngest such entry (closest to wr_ptr). lk_hit2 / lk_data2 behave identically for lk_reg2.
  - Lookups are purely combinational and do not see the entry being pushed in the same cycle.
  - An entry being popped this cycle is still visible until the posedge.
- Not defined: lk_hit1 = lk_hit2 = 0 and lk_data1 = lk_data2 = 0 constantly; no comparator logic is synthesised; ports remain present.

Test Plan:
- Single write: empty buffer, push (reg 5, 0x0000_00AA) -> next cycle Reg_Write=1, Write_Reg=5, Write_Data=0xAA; the following cycle empty=1 and Reg_Write=0.
- Fill/backpressure: drain_hold=1, push 4 entries (regs 1..4, data 0x11..0x44) -> full=1, in_ready=0, count=4, Reg_Write=0. A 5th in_valid is not accepted. Release hold -> writes drain 1,2,3,4 on consecutive cycles.
- Register 0 drop: push (reg 0, 0xDEAD_BEEF) -> count stays 0, Reg_Write never asserts, in_ready stayed 1.
- Simultaneous push/pop: count=2 (hold=0), push each cycle for 3 cycles -> count stays 2, outputs follow in-order sequence with no gap.
- Bypass (WRBUF_BYPASS_EN, hold=1): push (7, 0x1) then (7, 0x2), lk_reg1=7, lk_reg2=0 -> lk_hit1=1, lk_data1=0x2, lk_hit2=0. Without the macro -> lk_hit1=0.
- Reset mid-operation: count=3, assert rst asynchronously mid-cycle -> Reg_Write, count, full fall to 0 immediately; after release no stale writes appear and in_ready=1.
